// File: rtl/seg_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display_if
// Description : Digit/display bundle for the seven-segment scanner.
//               master : digit source (drives num1..num4, blank; sees an/seg)
//               slave  : display scanner (reads digits, drives an/seg)
// Signals     : num1..num4 [3:0]  digits, num1 leftmost
//               blank            1 = all anodes off
//               an [3:0]         anode enables, an[3] = num1 position
//               seg [6:0]        segments {g,f,e,d,c,b,a}
// Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_display_if;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (
        output num1, num2, num3, num4, blank,
        input  an, seg
    );

    modport slave (
        input  num1, num2, num3, num4, blank,
        output an, seg
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : 4-digit multiplexed seven-segment scanner. Digits are
//               latched once per frame so a change mid-scan cannot tear the
//               display, each slot opens with anode dead time against
//               ghosting, and leading zeros may be suppressed.
// Ports       : clk          system clock
//               reset        asynchronous active-high reset
//               bus (slave)  num1..num4, blank in; an, seg out (registered)
// Parameters  : SCAN_DIV      clk cycles per digit slot (>= DEAD_CYCLES+2)
//               DEAD_CYCLES   cycles at slot start with all anodes off
//               LEADING_BLANK 1 = suppress leading zeros (num4 always shown)
//               ACTIVE_LOW    1 = an/seg active-low
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_display #(
    parameter int SCAN_DIV      = 50000,
    parameter int DEAD_CYCLES   = 500,
    parameter int LEADING_BLANK = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_display_if.slave  bus
);

    localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last   = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      c_an_off  = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
    localparam logic [6:0]      c_seg_off = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_d1;
    logic [3:0]       r_d2;
    logic [3:0]       r_d3;
    logic [3:0]       r_d4;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_tick;
    logic             w_live;
    logic             w_lz;
    logic             w_on;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_hi;
    logic [3:0]       w_an_hi;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;

    // Wrap by compare so non-power-of-two dividers work.
    assign w_tick = (r_cnt == c_last);

    // With no dead time the compare would be trivially true.
    generate
        if (DEAD_CYCLES == 0) begin : g_dead_none
            assign w_live = 1'b1;
        end else begin : g_dead_cmp
            localparam logic [CNT_W-1:0] c_dead = CNT_W'(DEAD_CYCLES);
            assign w_live = (r_cnt >= c_dead);
        end
    endgenerate

    // Select the shadow digit of the current slot and decide whether it is a
    // leading zero. The rightmost position is always shown.
    always_comb begin
        w_digit = r_d4;
        w_lz    = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit = r_d1;
                w_lz    = (r_d1 == 4'd0);
            end
            2'd1: begin
                w_digit = r_d2;
                w_lz    = (r_d1 == 4'd0) && (r_d2 == 4'd0);
            end
            2'd2: begin
                w_digit = r_d3;
                w_lz    = (r_d1 == 4'd0) && (r_d2 == 4'd0) && (r_d3 == 4'd0);
            end
            default: begin
                w_digit = r_d4;
                w_lz    = 1'b0;
            end
        endcase
        if (LEADING_BLANK == 0) begin
            w_lz = 1'b0;
        end
    end

    // Active-high gfedcba decode.
    always_comb begin
        w_seg_hi = 7'h00;
        case (w_digit)
            4'h0: w_seg_hi = 7'h3F;
            4'h1: w_seg_hi = 7'h06;
            4'h2: w_seg_hi = 7'h5B;
            4'h3: w_seg_hi = 7'h4F;
            4'h4: w_seg_hi = 7'h66;
            4'h5: w_seg_hi = 7'h6D;
            4'h6: w_seg_hi = 7'h7D;
            4'h7: w_seg_hi = 7'h07;
            4'h8: w_seg_hi = 7'h7F;
            4'h9: w_seg_hi = 7'h6F;
            4'hA: w_seg_hi = 7'h77;
            4'hB: w_seg_hi = 7'h7C;
            4'hC: w_seg_hi = 7'h39;
            4'hD: w_seg_hi = 7'h5E;
            4'hE: w_seg_hi = 7'h79;
            default: w_seg_hi = 7'h71;
        endcase
    end

    // Slot 0 is the leftmost digit, driven on an[3].
    assign w_an_hi = 4'b1000 >> r_idx;
    assign w_on    = w_live && !bus.blank && !w_lz;

    always_comb begin
        w_an_nxt  = w_on ? w_an_hi  : 4'h0;
        w_seg_nxt = w_on ? w_seg_hi : 7'h00;
        if (ACTIVE_LOW != 0) begin
            w_an_nxt  = ~w_an_nxt;
            w_seg_nxt = ~w_seg_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_d3  <= 4'd0;
            r_d4  <= 4'd0;
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            // Frame latch: new digits only at the end of the last slot.
            if (w_tick && (r_idx == 2'd3)) begin
                r_d1 <= bus.num1;
                r_d2 <= bus.num2;
                r_d3 <= bus.num3;
                r_d4 <= bus.num4;
            end
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Scoreboard bench for seg_scan_display. Two instances run in
//               lockstep on shared inputs: u_dut0 shows all zeros, u_dut1
//               suppresses leading zeros. Stimulus pushes hand-computed
//               per-cycle expectations tagged with a cycle number; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_display;

    typedef struct {
        int         cyc;
        int         tag;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic [3:0] an1;
        logic [6:0] seg1;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] num1  = 4'd0;
    logic [3:0] num2  = 4'd0;
    logic [3:0] num3  = 4'd0;
    logic [3:0] num4  = 4'd0;
    logic       blank = 1'b0;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tag = 0;
    bit   final_chk = 1'b0;
    bit   final_done = 1'b0;
    exp_t q[$];
    exp_t e_mon;

    seg_scan_display_if bus0 ();
    seg_scan_display_if bus1 ();

    assign bus0.num1  = num1;
    assign bus0.num2  = num2;
    assign bus0.num3  = num3;
    assign bus0.num4  = num4;
    assign bus0.blank = blank;
    assign bus1.num1  = num1;
    assign bus1.num2  = num2;
    assign bus1.num3  = num3;
    assign bus1.num4  = num4;
    assign bus1.blank = blank;

    seg_scan_display #(
        .SCAN_DIV(8), .DEAD_CYCLES(2), .LEADING_BLANK(0), .ACTIVE_LOW(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    seg_scan_display #(
        .SCAN_DIV(8), .DEAD_CYCLES(2), .LEADING_BLANK(1), .ACTIVE_LOW(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one-hot anode check every cycle, then drain expectations due now.
    always @(negedge clk) begin
        total++;
        if ($countones(~bus0.an) > 1) begin
            bad++;
            $display("FAIL onehot0 cyc=%0d an=%b required at most one low", cyc, bus0.an);
        end
        total++;
        if ($countones(~bus1.an) > 1) begin
            bad++;
            $display("FAIL onehot1 cyc=%0d an=%b required at most one low", cyc, bus1.an);
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_mon = q.pop_front();
            if (e_mon.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL stale t%0d expectation for cyc=%0d seen at cyc=%0d", e_mon.tag, e_mon.cyc, cyc);
            end else begin
                total++;
                if (bus0.an !== e_mon.an0) begin
                    bad++;
                    $display("FAIL t%0d an0 cyc=%0d got=%b exp=%b", e_mon.tag, cyc, bus0.an, e_mon.an0);
                end
                total++;
                if (bus0.seg !== e_mon.seg0) begin
                    bad++;
                    $display("FAIL t%0d seg0 cyc=%0d got=%h exp=%h", e_mon.tag, cyc, bus0.seg, e_mon.seg0);
                end
                total++;
                if (bus1.an !== e_mon.an1) begin
                    bad++;
                    $display("FAIL t%0d an1 cyc=%0d got=%b exp=%b", e_mon.tag, cyc, bus1.an, e_mon.an1);
                end
                total++;
                if (bus1.seg !== e_mon.seg1) begin
                    bad++;
                    $display("FAIL t%0d seg1 cyc=%0d got=%h exp=%h", e_mon.tag, cyc, bus1.seg, e_mon.seg1);
                end
            end
        end
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL drain left=%0d required=0", q.size());
            end
        end
    end

    // Push the expectation for the outputs visible in the current cycle,
    // then move to just after the next rising edge.
    task automatic ex(input logic [3:0] a0, input logic [6:0] s0,
                      input logic [3:0] a1, input logic [6:0] s1);
        exp_t e;
        e.cyc  = cyc;
        e.tag  = tag;
        e.an0  = a0;
        e.seg0 = s0;
        e.an1  = a1;
        e.seg1 = s1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic off(input int n);
        for (int i = 0; i < n; i++) ex(4'hF, 7'h7F, 4'hF, 7'h7F);
    endtask

    // One 8-cycle slot: 2 dead cycles, then 6 active cycles.
    task automatic slot(input logic [3:0] a0, input logic [6:0] s0,
                        input logic [3:0] a1, input logic [6:0] s1);
        off(2);
        for (int i = 0; i < 6; i++) ex(a0, s0, a1, s1);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        off(2);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_num(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        num1 = a;
        num2 = b;
        num3 = c;
        num4 = d;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset, then first frame shows the zeroed shadow.
        tag = 1;
        set_num(4'd1, 4'd0, 4'd2, 4'd3);
        do_reset();
        slot(4'h7, 7'h40, 4'hF, 7'h7F);
        slot(4'hB, 7'h40, 4'hF, 7'h7F);
        slot(4'hD, 7'h40, 4'hF, 7'h7F);
        slot(4'hE, 7'h40, 4'hE, 7'h40);

        // Second frame shows 1023; next frame's digits loaded meanwhile.
        set_num(4'd0, 4'd0, 4'd5, 4'd0);
        slot(4'h7, 7'h79, 4'h7, 7'h79);
        slot(4'hB, 7'h40, 4'hB, 7'h40);
        slot(4'hD, 7'h24, 4'hD, 7'h24);
        slot(4'hE, 7'h30, 4'hE, 7'h30);

        // 0050: leading zeros blanked on u_dut1 only.
        tag = 3;
        set_num(4'd1, 4'd1, 4'd1, 4'd1);
        slot(4'h7, 7'h40, 4'hF, 7'h7F);
        slot(4'hB, 7'h40, 4'hF, 7'h7F);
        slot(4'hD, 7'h12, 4'hD, 7'h12);
        slot(4'hE, 7'h40, 4'hE, 7'h40);

        // Tearing: change digits once idx=1; frame stays 1111.
        tag = 4;
        slot(4'h7, 7'h79, 4'h7, 7'h79);
        set_num(4'd2, 4'd2, 4'd2, 4'd2);
        slot(4'hB, 7'h79, 4'hB, 7'h79);
        slot(4'hD, 7'h79, 4'hD, 7'h79);
        slot(4'hE, 7'h79, 4'hE, 7'h79);
        slot(4'h7, 7'h24, 4'h7, 7'h24);
        slot(4'hB, 7'h24, 4'hB, 7'h24);
        slot(4'hD, 7'h24, 4'hD, 7'h24);
        slot(4'hE, 7'h24, 4'hE, 7'h24);

        // Blank for 20 cycles; scan keeps running underneath.
        tag = 5;
        blank = 1'b1;
        off(20);
        blank = 1'b0;
        off(1);
        for (int i = 0; i < 3; i++) ex(4'hD, 7'h24, 4'hD, 7'h24);
        slot(4'hE, 7'h24, 4'hE, 7'h24);

        // Reset at idx=2, cnt=5: outputs go off in the same cycle.
        tag = 6;
        slot(4'h7, 7'h24, 4'h7, 7'h24);
        slot(4'hB, 7'h24, 4'hB, 7'h24);
        off(2);
        ex(4'hD, 7'h24, 4'hD, 7'h24);
        ex(4'hD, 7'h24, 4'hD, 7'h24);
        do_reset();
        slot(4'h7, 7'h40, 4'hF, 7'h7F);
        slot(4'hB, 7'h40, 4'hF, 7'h7F);

        repeat (2) @(posedge clk);
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
